// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with integrated RV32I/RV64I + M-extension decode.
// Single-cycle ops register their result on the accept edge; MUL/DIV/REM share one iterative datapath.
module alu_exec_unit #(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_illegal,
  output logic            busy,
  output logic [1:0]      o_dbg_state
);

  // Handshake: an input transfer happens on a rising edge where in_valid & in_ready,
  // an output transfer where out_valid & out_ready; out_valid/result/out_illegal hold until taken.

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic              r_a_neg;
  logic              r_b_neg;
  logic              r_dz;
  op_t               r_mop;
  logic [XLEN-1:0]   r_result;
  logic              r_out_valid;
  logic              r_out_illegal;

  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  op_t               w_op;
  logic              w_is_m;
  logic              w_is_div;
  logic              w_accept;
  logic [SW-1:0]     w_shamt;
  logic [XLEN-1:0]   w_alu;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_iter_div;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN+1:0]   w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix;
  logic              w_unused;

  function automatic op_t base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = alt ? OP_SRA : OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  function automatic op_t m_op(input logic [2:0] f3);
    case (f3)
      3'b000:  m_op = OP_MUL;
      3'b001:  m_op = OP_MULH;
      3'b010:  m_op = OP_MULHSU;
      3'b011:  m_op = OP_MULHU;
      3'b100:  m_op = OP_DIV;
      3'b101:  m_op = OP_DIVU;
      3'b110:  m_op = OP_REM;
      default: m_op = OP_REMU;
    endcase
  endfunction

  assign w_f3 = instr[14:12];
  assign w_f7 = instr[31:25];

  always_comb begin
    w_op = OP_ILL;
    case (alu_op)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        if (w_f7 == 7'b0000000) begin
          w_op = base_op(w_f3, 1'b0);
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_op = OP_SUB;
          else if (w_f3 == 3'b101) w_op = OP_SRA;
          else                     w_op = OP_ILL;
        end else if ((w_f7 == 7'b0000001) && EN_MULDIV) begin
          w_op = m_op(w_f3);
        end else begin
          w_op = OP_ILL;
        end
      end
      default: begin
        // I-type: instr[30] only matters for the right shift; a SLLI with it set is malformed.
        if ((w_f3 == 3'b001) && instr[30]) w_op = OP_ILL;
        else                               w_op = base_op(w_f3, instr[30]);
      end
    endcase
  end

  assign w_is_m   = (w_op == OP_MUL)  || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                    (w_op == OP_MULHU) || w_is_div;
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU) || (w_op == OP_REM) || (w_op == OP_REMU);
  assign in_ready = (r_state == S_IDLE) & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_shamt  = op_b[SW-1:0];

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = op_a + op_b;
      OP_SUB:  w_alu = op_a - op_b;
      OP_SLL:  w_alu = op_a << w_shamt;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  w_alu = op_a ^ op_b;
      OP_SRL:  w_alu = op_a >> w_shamt;
      OP_SRA:  w_alu = $signed(op_a) >>> w_shamt;
      OP_OR:   w_alu = op_a | op_b;
      OP_AND:  w_alu = op_a & op_b;
      default: w_alu = '0;
    endcase
  end

  // The iterative datapath works on magnitudes; signs are re-applied in FIX.
  assign w_a_sgn = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                   (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_sgn = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg = w_a_sgn & op_a[XLEN-1];
  assign w_b_neg = w_b_sgn & op_b[XLEN-1];
  assign w_abs_a = w_a_neg ? -op_a : op_a;
  assign w_abs_b = w_b_neg ? -op_b : op_b;

  // Multiply: {r_hi,r_lo} shifts right, multiplier consumed from r_lo[0].
  // Divide: restoring, partial remainder in r_hi, dividend shifts out of r_lo as quotient shifts in.
  assign w_iter_div = (r_mop == OP_DIV) || (r_mop == OP_DIVU) || (r_mop == OP_REM) || (r_mop == OP_REMU);
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_rem_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_qbit     = ~w_diff[XLEN+1];

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
  assign w_quo    = r_dz ? {XLEN{1'b1}} : ((r_a_neg ^ r_b_neg) ? -r_lo : r_lo);
  assign w_rem    = r_a_neg ? -r_hi : r_hi;

  always_comb begin
    w_fix = '0;
    case (r_mop)
      OP_MUL:                        w_fix = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix = w_quo;
      OP_REM, OP_REMU:               w_fix = w_rem;
      default:                       w_fix = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_m) w_state_nxt = S_ITER;
      S_ITER:  if (r_cnt == SW'(XLEN-1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_b           <= '0;
      r_a_neg       <= 1'b0;
      r_b_neg       <= 1'b0;
      r_dz          <= 1'b0;
      r_mop         <= OP_ADD;
      r_result      <= '0;
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_m) begin
            r_hi          <= '0;
            r_lo          <= w_is_div ? w_abs_a : w_abs_b;
            r_b           <= w_is_div ? w_abs_b : w_abs_a;
            r_a_neg       <= w_a_neg;
            r_b_neg       <= w_b_neg;
            r_dz          <= (op_b == '0);
            r_mop         <= w_op;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
          end else if (w_accept) begin
            r_result      <= (w_op == OP_ILL) ? '0 : w_alu;
            r_out_illegal <= (w_op == OP_ILL);
            r_out_valid   <= 1'b1;
          end else if (out_ready) begin
            r_out_valid   <= 1'b0;
          end
        end
        S_ITER: begin
          if (w_iter_div) begin
            r_hi <= w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_qbit};
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_result      <= w_fix;
          r_out_illegal <= 1'b0;
          r_out_valid   <= 1'b1;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign out_illegal = r_out_illegal;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  // Fields of the instruction word the ALU never looks at, plus the diff carry bit.
  assign w_unused = ^{instr[24:15], instr[11:0], w_diff[XLEN]};

endmodule
